sram_d_arbiter: RTL and testbench

Round-robin OBI arbiter that shares the single data port of the SRAM wrapper between `NUM_REQ` requesters, such as the core data port, a DMA engine and the debug/bus bridge. It sits between the requester-side OBI interconnect and the SRAM wrapper's `sram_d_*` port. It selects one requester per cycle and forwards its request downstream. An owner-ID FIFO tracks every accepted transaction, so each `rvalid`/`rdata` beat returns to the requester that issued it, including back-to-back pipelined accesses.

---
 rtl/sram_d_arbiter.sv | 134 +++++++++++++
 tb/tb_sram_d_arbiter.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_d_arbiter.sv
// Round-robin OBI arbiter sharing one SRAM data port between NUM_REQ requesters.
// An owner-ID FIFO routes each rvalid beat back to the requester that was granted.
module sram_d_arbiter #(
  parameter int NUM_REQ         = 2,
  parameter int MAX_OUTSTANDING = 2,
  parameter int ID_W            = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NUM_REQ-1:0]     req_i,
  output logic [NUM_REQ-1:0]     gnt_o,
  input  logic [NUM_REQ*32-1:0]  addr_i,
  input  logic [NUM_REQ-1:0]     we_i,
  input  logic [NUM_REQ*4-1:0]   be_i,
  input  logic [NUM_REQ*32-1:0]  wdata_i,
  output logic [NUM_REQ-1:0]     rvalid_o,
  output logic [31:0]            rdata_o,
  output logic                   sram_req_o,
  input  logic                   sram_gnt_i,
  output logic [31:0]            sram_addr_o,
  output logic                   sram_we_o,
  output logic [3:0]             sram_be_o,
  output logic [31:0]            sram_wdata_o,
  input  logic                   sram_rvalid_i,
  input  logic [31:0]            sram_rdata_i,
  output logic                   err_o
);

  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [ID_W:0]    NUM_REQ_EXT = (ID_W + 1)'(NUM_REQ);
  localparam logic [ID_W-1:0]  LAST_ID     = ID_W'(NUM_REQ - 1);
  localparam logic [PTR_W-1:0] LAST_PTR    = PTR_W'(MAX_OUTSTANDING - 1);
  localparam logic [CNT_W-1:0] MAX_CNT     = CNT_W'(MAX_OUTSTANDING);

  logic [31:0]      addr_arr  [NUM_REQ];
  logic [3:0]       be_arr    [NUM_REQ];
  logic [31:0]      wdata_arr [NUM_REQ];

  logic [ID_W-1:0]  rr_q;
  logic [ID_W-1:0]  sel;
  logic [ID_W-1:0]  cand;
  logic [ID_W:0]    cand_sum;
  logic             found;

  logic [ID_W-1:0]  fifo_q [MAX_OUTSTANDING];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [ID_W-1:0]  head;
  logic             err_q;

  logic             any_req;
  logic             can_issue;
  logic             handshake;
  logic             pop;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_port
    assign addr_arr[gi]  = addr_i[32*gi +: 32];
    assign be_arr[gi]    = be_i[4*gi +: 4];
    assign wdata_arr[gi] = wdata_i[32*gi +: 32];
    assign gnt_o[gi]     = handshake && (sel == ID_W'(gi));
    assign rvalid_o[gi]  = pop && (head == ID_W'(gi));
  end

  // Scan rr_q, rr_q+1, ... (mod NUM_REQ); the first active request wins.
  always_comb begin
    sel      = '0;
    found    = 1'b0;
    cand     = '0;
    cand_sum = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand_sum = {1'b0, rr_q} + (ID_W + 1)'(i);
      if (cand_sum >= NUM_REQ_EXT) begin
        cand_sum = cand_sum - NUM_REQ_EXT;
      end
      cand = cand_sum[ID_W-1:0];
      if (!found && req_i[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  assign any_req   = |req_i;
  // A response in the same cycle frees a slot, so a full FIFO still accepts.
  assign can_issue = (count_q < MAX_CNT) || sram_rvalid_i;
  assign sram_req_o = any_req && can_issue && rst_ni;
  assign handshake = sram_req_o && sram_gnt_i;
  assign pop       = sram_rvalid_i && (count_q != '0);

  assign sram_addr_o  = any_req ? addr_arr[sel]  : '0;
  assign sram_we_o    = any_req ? we_i[sel]      : 1'b0;
  assign sram_be_o    = any_req ? be_arr[sel]    : '0;
  assign sram_wdata_o = any_req ? wdata_arr[sel] : '0;

  assign head    = fifo_q[rd_ptr_q];
  assign rdata_o = sram_rdata_i;
  assign err_o   = err_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q     <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      if (handshake) begin
        wr_ptr_q <= (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
        rr_q     <= (sel == LAST_ID) ? '0 : sel + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
      end
      if (handshake && !pop) begin
        count_q <= count_q + 1'b1;
      end else if (!handshake && pop) begin
        count_q <= count_q - 1'b1;
      end
      if (sram_rvalid_i && (count_q == '0)) begin
        err_q <= 1'b1;
      end
    end
  end

  // Owner storage needs no reset: entries are only read while count_q > 0.
  always_ff @(posedge clk_i) begin
    if (handshake) begin
      fifo_q[wr_ptr_q] <= sel;
    end
  end

endmodule

// File: tb/tb_sram_d_arbiter.sv
// Bench for sram_d_arbiter: SRAM stub with configurable latency, per-cycle
// reference model with an owner scoreboard, a vector table and corner sequences.
module tb_sram_d_arbiter;

  localparam int N    = 2;
  localparam int MAXO = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N-1:0]     req, gnt, we, rvalid;
  logic [N*32-1:0]  addr, wdata;
  logic [N*4-1:0]   be;
  logic [31:0]      rdata, sram_addr, sram_wdata, sram_rdata;
  logic             sram_req, sram_gnt, sram_we, sram_rvalid, err;
  logic [3:0]       sram_be;

  always #5 clk = ~clk;

  sram_d_arbiter #(.NUM_REQ(N), .MAX_OUTSTANDING(MAXO)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_i(req), .gnt_o(gnt), .addr_i(addr), .we_i(we), .be_i(be), .wdata_i(wdata),
    .rvalid_o(rvalid), .rdata_o(rdata),
    .sram_req_o(sram_req), .sram_gnt_i(sram_gnt), .sram_addr_o(sram_addr),
    .sram_we_o(sram_we), .sram_be_o(sram_be), .sram_wdata_o(sram_wdata),
    .sram_rvalid_i(sram_rvalid), .sram_rdata_i(sram_rdata), .err_o(err)
  );

  int n_checks = 0;
  int n_errors = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endfunction

  function automatic logic [31:0] mem_word(logic [31:0] a);
    if (a == 32'h8000_0010) return 32'hDEAD_BEEF;
    return {a[15:0], a[31:16]} ^ 32'h1234_5678;
  endfunction

  function automatic logic [31:0] base_addr(int k);
    if (k == 0) return 32'h8000_0010;
    return 32'h8000_1000 + 32'(k) * 32'h100;
  endfunction

  // SRAM stub: responds lat cycles after each handshake; spur injects a stray rvalid.
  int          lat = 1;
  logic        spur = 1'b0;
  logic [3:0]  pv = '0;
  logic [31:0] pd [4];

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      pv[i] <= pv[i+1];
      pd[i] <= pd[i+1];
    end
    pv[3] <= 1'b0;
    if (sram_req && sram_gnt) begin
      pv[lat-1] <= 1'b1;
      pd[lat-1] <= mem_word(sram_addr);
    end
  end

  assign sram_rvalid = pv[0] | spur;
  assign sram_rdata  = pd[0];

  // Reference model and owner scoreboard, evaluated mid-cycle.
  typedef struct {
    int          owner;
    logic        we;
    logic [31:0] data;
  } sb_t;

  sb_t  sb[$];
  int   rr_m  = 0;
  logic err_m = 1'b0;

  always @(negedge clk) begin : monitor
    int           win;
    logic         exp_can, exp_sreq;
    logic [N-1:0] exp_gnt, exp_rv;
    sb_t          e;
    if (!rst_n) begin
      check("rst_gnt", 32'(gnt), 32'd0);
      check("rst_rvalid", 32'(rvalid), 32'd0);
      check("rst_sram_req", 32'(sram_req), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      sb.delete();
      rr_m  = 0;
      err_m = 1'b0;
    end else begin
      check("err", 32'(err), 32'(err_m));
      exp_can  = (sb.size() < MAXO) || sram_rvalid;
      exp_sreq = (|req) && exp_can;
      win = -1;
      for (int i = 0; i < N; i++) begin
        if (win < 0 && req[(rr_m + i) % N]) win = (rr_m + i) % N;
      end
      exp_gnt = '0;
      if (exp_sreq && sram_gnt) exp_gnt[win] = 1'b1;
      check("sram_req", 32'(sram_req), 32'(exp_sreq));
      check("gnt", 32'(gnt), 32'(exp_gnt));
      if (win >= 0) begin
        check("sram_addr", sram_addr, addr[32*win +: 32]);
        check("sram_we", 32'(sram_we), 32'(we[win]));
        check("sram_be", 32'(sram_be), 32'(be[4*win +: 4]));
        check("sram_wdata", sram_wdata, wdata[32*win +: 32]);
      end else begin
        check("idle_addr", sram_addr, 32'd0);
      end
      exp_rv = '0;
      if (sram_rvalid) begin
        if (sb.size() > 0) begin
          e = sb.pop_front();
          exp_rv[e.owner] = 1'b1;
          if (!e.we) check("rdata", rdata, e.data);
          $display("txn owner=%0d we=%0b rdata=0x%08h", e.owner, e.we, rdata);
        end else begin
          err_m = 1'b1;
        end
      end
      check("rvalid", 32'(rvalid), 32'(exp_rv));
      if (exp_gnt != '0) begin
        sb.push_back('{owner: win, we: we[win], data: mem_word(addr[32*win +: 32])});
        rr_m = (win + 1) % N;
      end
    end
  end

  // Driver: one call = one clock cycle; samples the DUT mid-cycle.
  int           txn [N];
  logic [N-1:0] gnt_s, rvalid_s;
  logic         sreq_s, err_s;
  logic [31:0]  rdata_s;

  task automatic apply(input logic [N-1:0] r, input logic [N-1:0] w,
                       input logic g, input logic sp);
    req      = r;
    we       = w;
    sram_gnt = g;
    spur     = sp;
    for (int k = 0; k < N; k++) begin
      addr[32*k +: 32]  = base_addr(k) + 32'(txn[k]) * 32'd4;
      wdata[32*k +: 32] = ~addr[32*k +: 32];
      be[4*k +: 4]      = w[k] ? 4'b0011 : 4'b1111;
    end
    @(negedge clk);
    gnt_s    = gnt;
    rvalid_s = rvalid;
    sreq_s   = sram_req;
    err_s    = err;
    rdata_s  = rdata;
    for (int k = 0; k < N; k++) if (gnt[k]) txn[k]++;
    @(posedge clk);
    #1;
    spur = 1'b0;
  endtask

  task automatic drain();
    for (int c = 0; c < 20 && (sb.size() > 0 || pv != '0); c++) apply('0, '0, 1'b1, 1'b0);
    check("drain_sb", 32'(sb.size()), 32'd0);
    check("drain_stub", 32'(pv), 32'd0);
  endtask

  task automatic do_reset();
    req   = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [N-1:0] req;
    logic [N-1:0] we;
    logic         g;
    logic [N-1:0] exp_gnt;
    logic [N-1:0] exp_rv;
  } vec_t;

  initial begin
    vec_t        vecs [10];
    logic        st_sreq [6];
    logic [1:0]  st_gnt [6];
    int          gcount, n0, n1, rv1;

    // req, we, sram_gnt, expected gnt, expected rvalid
    vecs[0] = '{2'b01, 2'b00, 1'b1, 2'b01, 2'b00};
    vecs[1] = '{2'b00, 2'b00, 1'b1, 2'b00, 2'b01};
    vecs[2] = '{2'b11, 2'b00, 1'b1, 2'b10, 2'b00};
    vecs[3] = '{2'b11, 2'b00, 1'b1, 2'b01, 2'b10};
    vecs[4] = '{2'b11, 2'b00, 1'b0, 2'b00, 2'b01};
    vecs[5] = '{2'b11, 2'b00, 1'b1, 2'b10, 2'b00};
    vecs[6] = '{2'b01, 2'b00, 1'b1, 2'b01, 2'b10};
    vecs[7] = '{2'b01, 2'b01, 1'b1, 2'b01, 2'b01};
    vecs[8] = '{2'b10, 2'b10, 1'b1, 2'b10, 2'b01};
    vecs[9] = '{2'b00, 2'b00, 1'b1, 2'b00, 2'b10};

    st_sreq = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    st_gnt  = '{2'b01, 2'b10, 2'b00, 2'b01, 2'b10, 2'b00};

    for (int k = 0; k < N; k++) txn[k] = 0;
    rst_n = 1'b0; req = '0; we = '0; addr = '0; wdata = '0; be = '0; sram_gnt = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_sram_req", 32'(sram_req), 32'd0);
    check("reset_gnt", 32'(gnt), 32'd0);
    check("reset_err", 32'(err), 32'd0);
    rst_n = 1'b1;

    // Vector table: single read, round-robin turns, a gnt stall, writes.
    for (int i = 0; i < 10; i++) begin
      apply(vecs[i].req, vecs[i].we, vecs[i].g, 1'b0);
      check($sformatf("tbl%0d_gnt", i), 32'(gnt_s), 32'(vecs[i].exp_gnt));
      check($sformatf("tbl%0d_rvalid", i), 32'(rvalid_s), 32'(vecs[i].exp_rv));
      check($sformatf("tbl%0d_err", i), 32'(err_s), 32'd0);
      if (i == 1) check("single_read_rdata", rdata_s, 32'hDEAD_BEEF);
    end
    drain();

    // Contention from reset: grants alternate 0,1,0,1...
    do_reset();
    gcount = 0; n0 = 0; n1 = 0;
    for (int c = 0; c < 30 && (n0 < 4 || n1 < 4); c++) begin
      apply({n1 < 4, n0 < 4}, '0, 1'b1, 1'b0);
      if (gnt_s != '0) begin
        check("contention_order", 32'(gnt_s[1]), 32'(gcount % 2));
        gcount++;
        if (gnt_s[0]) n0++;
        if (gnt_s[1]) n1++;
      end
    end
    check("contention_count", 32'(gcount), 32'd8);
    drain();

    // Back-to-back pipelined reads from requester 1.
    rv1 = 0;
    for (int i = 0; i < 8; i++) begin
      apply(2'b10, '0, 1'b1, 1'b0);
      check("pipe_gnt", 32'(gnt_s), 32'(2'b10));
      if (rvalid_s[1]) rv1++;
    end
    for (int i = 0; i < 2; i++) begin
      apply('0, '0, 1'b1, 1'b0);
      if (rvalid_s[1]) rv1++;
    end
    check("pipe_beats", 32'(rv1), 32'd8);
    drain();

    // FIFO-full stall with 3-cycle responses; rr_q holds across the stall.
    do_reset();
    lat = 3;
    for (int i = 0; i < 6; i++) begin
      apply(2'b11, '0, 1'b1, 1'b0);
      check($sformatf("stall%0d_sreq", i), 32'(sreq_s), 32'(st_sreq[i]));
      check($sformatf("stall%0d_gnt", i), 32'(gnt_s), 32'(st_gnt[i]));
    end
    drain();

    // Spurious response sets a sticky error.
    lat = 1;
    apply('0, '0, 1'b1, 1'b1);
    check("spur_rvalid", 32'(rvalid_s), 32'd0);
    check("spur_err_same_cycle", 32'(err_s), 32'd0);
    for (int i = 0; i < 3; i++) begin
      apply('0, '0, 1'b1, 1'b0);
      check("spur_err_sticky", 32'(err_s), 32'd1);
    end

    // Reset with two outstanding; the second late response lands after release.
    lat = 3;
    apply(2'b11, '0, 1'b1, 1'b0);
    apply(2'b11, '0, 1'b1, 1'b0);
    check("midrst_outstanding", 32'(sb.size()), 32'd2);
    rst_n = 1'b0;
    #1;
    check("async_rst_gnt", 32'(gnt), 32'd0);
    check("async_rst_sram_req", 32'(sram_req), 32'd0);
    check("async_rst_rvalid", 32'(rvalid), 32'd0);
    check("async_rst_err", 32'(err), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    apply(2'b11, '0, 1'b1, 1'b0);
    check("post_rst_gnt", 32'(gnt_s), 32'(2'b01));
    check("late_rvalid_dropped", 32'(rvalid_s), 32'd0);
    apply(2'b10, '0, 1'b1, 1'b0);
    check("late_rvalid_err", 32'(err_s), 32'd1);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
